// File: rtl/sram_axi_pkg.sv
// Shared types and AXI constants for the SRAM-like to AXI3 bridge.
package sram_axi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StWrWait
  } ch_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } ch_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, first eligible at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [N-1:0]    i_eligible,
  input  logic            i_advance,
  output logic [N-1:0]    o_grant,
  output logic [PtrW-1:0] o_grant_idx,
  output logic [PtrW-1:0] o_ptr
);

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_idx;
  logic [PtrW-1:0] w_next;
  logic [N-1:0]    w_grant;
  logic            w_found;

  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      int j;
      j = int'(r_ptr) + i;
      if (j >= int'(N)) j = j - int'(N);
      if (!w_found && i_eligible[j]) begin
        w_found    = 1'b1;
        w_grant[j] = 1'b1;
        w_idx      = PtrW'(j);
      end
    end
  end

  assign w_next = (w_idx == PtrW'(N - 1)) ? '0 : w_idx + PtrW'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= w_next;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;
  assign o_ptr       = r_ptr;

endmodule

// File: rtl/sram_axi_mux.sv
// NUM_CH SRAM-like channels arbitrated round-robin onto one AXI3 master, single-beat only.
module sram_axi_mux
  import sram_axi_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ID_W      = 4,
  parameter bit          RAW_CHECK = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_CH-1:0]       i_ch_req,
  input  logic [NUM_CH-1:0]       i_ch_wr,
  input  logic [NUM_CH-1:0][1:0]  i_ch_size,
  input  logic [NUM_CH-1:0][31:0] i_ch_addr,
  input  logic [NUM_CH-1:0][31:0] i_ch_wdata,
  input  logic [NUM_CH-1:0][3:0]  i_ch_wstrb,
  output logic [NUM_CH-1:0]       o_ch_addr_ok,
  output logic [NUM_CH-1:0]       o_ch_data_ok,
  output logic [31:0]             o_ch_rdata,
  output logic [ID_W-1:0]         o_arid,
  output logic [31:0]             o_araddr,
  output logic [3:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  output logic [1:0]              o_arlock,
  output logic [3:0]              o_arcache,
  output logic [2:0]              o_arprot,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  input  logic [ID_W-1:0]         i_rid,
  input  logic [31:0]             i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rlast,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  output logic [ID_W-1:0]         o_awid,
  output logic [31:0]             o_awaddr,
  output logic [3:0]              o_awlen,
  output logic [2:0]              o_awsize,
  output logic [1:0]              o_awburst,
  output logic [1:0]              o_awlock,
  output logic [3:0]              o_awcache,
  output logic [2:0]              o_awprot,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [ID_W-1:0]         o_wid,
  output logic [31:0]             o_wdata,
  output logic [3:0]              o_wstrb,
  output logic                    o_wlast,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  input  logic [ID_W-1:0]         i_bid,
  input  logic [1:0]              i_bresp,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  output logic                    o_err_bad_id
);

  localparam int unsigned PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  ch_state_t         r_state [NUM_CH];
  logic [NUM_CH-1:0] r_data_ok;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              r_arvalid, r_awvalid, r_wvalid, r_wr_inflight;
  logic [ID_W-1:0]   r_arid, r_awid;
  logic [31:0]       r_araddr, r_awaddr, r_wdata;
  logic [1:0]        r_arsize, r_awsize;
  logic [3:0]        r_wstrb;
  logic [29:0]       r_wr_addr;

  ch_req_t           w_req [NUM_CH];
  ch_req_t           w_sel;
  logic [NUM_CH-1:0] w_elig, w_grant, w_r_hit, w_b_hit;
  logic [PtrW-1:0]   w_gidx, w_ptr;
  logic              w_accept, w_ar_ok, w_wr_ok, w_wr_done;
  logic              w_unused;

  assign w_ar_ok = !r_arvalid || i_arready;
  assign w_wr_ok = !r_wr_inflight && !r_awvalid && !r_wvalid;

  always_comb begin
    w_elig    = '0;
    w_r_hit   = '0;
    w_b_hit   = '0;
    w_wr_done = 1'b0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      w_req[c] = '{wr: i_ch_wr[c], size: i_ch_size[c], addr: i_ch_addr[c],
                   wdata: i_ch_wdata[c], wstrb: i_ch_wstrb[c]};
      if (!i_reset && i_ch_req[c] && r_state[c] == StIdle) begin
        if (i_ch_wr[c]) w_elig[c] = w_wr_ok;
        else w_elig[c] = w_ar_ok &&
            !(RAW_CHECK && r_wr_inflight && i_ch_addr[c][31:2] == r_wr_addr);
      end
      // A channel already pulsing data_ok has consumed its response.
      w_r_hit[c] = i_rvalid && i_rid == ID_W'(c) && r_state[c] == StRdWait && !r_data_ok[c];
      w_b_hit[c] = i_bvalid && i_bid == ID_W'(c) && r_state[c] == StWrWait && !r_data_ok[c];
      if (r_data_ok[c] && r_state[c] == StWrWait) w_wr_done = 1'b1;
    end
  end

  rr_arbiter #(
    .N(NUM_CH)
  ) u_arb (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_eligible (w_elig),
    .i_advance  (w_accept),
    .o_grant    (w_grant),
    .o_grant_idx(w_gidx),
    .o_ptr      (w_ptr)
  );

  assign w_accept = |w_grant;
  assign w_sel    = w_req[w_gidx];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int c = 0; c < int'(NUM_CH); c++) r_state[c] <= StIdle;
      r_data_ok     <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_arvalid     <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_wr_inflight <= 1'b0;
      r_arid        <= '0;
      r_awid        <= '0;
      r_araddr      <= '0;
      r_awaddr      <= '0;
      r_wdata       <= '0;
      r_arsize      <= '0;
      r_awsize      <= '0;
      r_wstrb       <= '0;
      r_wr_addr     <= '0;
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (r_data_ok[c]) r_state[c] <= StIdle;
        else if (w_grant[c]) r_state[c] <= i_ch_wr[c] ? StWrWait : StRdWait;
      end
      r_data_ok <= w_r_hit | w_b_hit;
      if (|w_r_hit) r_rdata <= i_rdata;
      if ((i_rvalid && !(|w_r_hit)) || (i_bvalid && !(|w_b_hit))) r_err <= 1'b1;

      if (w_accept && !w_sel.wr) begin
        r_arvalid <= 1'b1;
        r_arid    <= ID_W'(w_gidx);
        r_araddr  <= w_sel.addr;
        r_arsize  <= w_sel.size;
      end else if (i_arready) begin
        r_arvalid <= 1'b0;
      end

      if (w_accept && w_sel.wr) begin
        r_awvalid     <= 1'b1;
        r_wvalid      <= 1'b1;
        r_wr_inflight <= 1'b1;
        r_awid        <= ID_W'(w_gidx);
        r_awaddr      <= w_sel.addr;
        r_awsize      <= w_sel.size;
        r_wdata       <= w_sel.wdata;
        r_wstrb       <= w_sel.wstrb;
        r_wr_addr     <= w_sel.addr[31:2];
      end else begin
        if (i_awready) r_awvalid <= 1'b0;
        if (i_wready) r_wvalid <= 1'b0;
        if (w_wr_done) r_wr_inflight <= 1'b0;
      end
    end
  end

  assign o_ch_addr_ok = w_grant;
  assign o_ch_data_ok = r_data_ok;
  assign o_ch_rdata   = r_rdata;
  assign o_err_bad_id = r_err;

  assign o_arid    = r_arid;
  assign o_araddr  = r_araddr;
  assign o_arlen   = AXI_LEN_SINGLE[3:0];
  assign o_arsize  = {1'b0, r_arsize};
  assign o_arburst = AXI_BURST_INCR;
  assign o_arlock  = 2'b00;
  assign o_arcache = 4'b0000;
  assign o_arprot  = 3'b000;
  assign o_arvalid = r_arvalid;
  assign o_rready  = 1'b1;

  assign o_awid    = r_awid;
  assign o_awaddr  = r_awaddr;
  assign o_awlen   = AXI_LEN_SINGLE[3:0];
  assign o_awsize  = {1'b0, r_awsize};
  assign o_awburst = AXI_BURST_INCR;
  assign o_awlock  = 2'b00;
  assign o_awcache = 4'b0000;
  assign o_awprot  = 3'b000;
  assign o_awvalid = r_awvalid;

  assign o_wid    = r_awid;
  assign o_wdata  = r_wdata;
  assign o_wstrb  = r_wstrb;
  assign o_wlast  = 1'b1;
  assign o_wvalid = r_wvalid;
  assign o_bready = 1'b1;

  assign w_unused = ^{i_rresp, i_rlast, i_bresp, w_ptr};

endmodule

// File: tb/tb_sram_axi_mux.sv
// Directed self-checking bench for sram_axi_mux with two channels and RAW checking enabled.
module tb_sram_axi_mux;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       ch_req, ch_wr, addr_ok, data_ok;
  logic [1:0][1:0]  ch_size;
  logic [1:0][31:0] ch_addr, ch_wdata;
  logic [1:0][3:0]  ch_wstrb;
  logic [31:0]      rdata_o;
  logic [3:0]  arid, awid, wid, rid, bid, arlen, awlen, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic arvalid, arready, awvalid, awready, wvalid, wready, wlast;
  logic rvalid, rlast, rready, bvalid, bready, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_axi_mux #(.NUM_CH(2), .ID_W(4), .RAW_CHECK(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_ch_req(ch_req), .i_ch_wr(ch_wr), .i_ch_size(ch_size),
    .i_ch_addr(ch_addr), .i_ch_wdata(ch_wdata), .i_ch_wstrb(ch_wstrb),
    .o_ch_addr_ok(addr_ok), .o_ch_data_ok(data_ok), .o_ch_rdata(rdata_o),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
    .o_arlock(arlock), .o_arcache(arcache), .o_arprot(arprot), .o_arvalid(arvalid),
    .i_arready(arready), .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast),
    .i_rvalid(rvalid), .o_rready(rready),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
    .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot), .o_awvalid(awvalid),
    .i_awready(awready), .o_wid(wid), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast),
    .o_wvalid(wvalid), .i_wready(wready), .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid),
    .o_bready(bready), .o_err_bad_id(err)
  );

  task automatic clear_inputs();
    ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0; ch_wstrb = '0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1;
    bvalid = 1'b0; bid = '0; bresp = '0;
  endtask

  // Returns at a falling edge with reset released; that cycle is c0 of the caller.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    ch_req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (addr_ok !== 2'b00) begin n_fail++; $display("FAIL rst_addr_ok: got %b want 00", addr_ok); end
    n_checks++; if (data_ok !== 2'b00) begin n_fail++; $display("FAIL rst_data_ok: got %b want 00", data_ok); end
    n_checks++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin n_fail++; $display("FAIL rst_valids: got %b want 000", {arvalid, awvalid, wvalid}); end
    n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_checks++; if ({rready, bready} !== 2'b11) begin n_fail++; $display("FAIL rst_readys: got %b want 11", {rready, bready}); end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    ch_req = 2'b01; ch_size[0] = 2'd2; ch_addr[0] = 32'h1000; arready = 1'b1;
    #1;
    n_checks++; if (addr_ok !== 2'b01) begin n_fail++; $display("FAIL rd_addr_ok: got %b want 01", addr_ok); end
    @(negedge clk); ch_req = 2'b00; #1;
    n_checks++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL rd_arvalid: got %b want 1", arvalid); end
    n_checks++; if (arid !== 4'd0) begin n_fail++; $display("FAIL rd_arid: got %h want 0", arid); end
    n_checks++; if (araddr !== 32'h1000) begin n_fail++; $display("FAIL rd_araddr: got %h want 1000", araddr); end
    n_checks++; if ({arlen, arsize, arburst} !== {4'd0, 3'd2, 2'b01}) begin n_fail++; $display("FAIL rd_arfields: got %h want %h", {arlen, arsize, arburst}, {4'd0, 3'd2, 2'b01}); end
    @(negedge clk); rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEADBEEF; #1;
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rd_ar_drop: got %b want 0", arvalid); end
    n_checks++; if (data_ok !== 2'b00) begin n_fail++; $display("FAIL rd_early_ok: got %b want 00", data_ok); end
    @(negedge clk); rvalid = 1'b0; #1;
    n_checks++; if (data_ok !== 2'b01) begin n_fail++; $display("FAIL rd_data_ok: got %b want 01", data_ok); end
    n_checks++; if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", rdata_o); end
    @(negedge clk); #1;
    n_checks++; if (data_ok !== 2'b00) begin n_fail++; $display("FAIL rd_pulse_len: got %b want 00", data_ok); end
  endtask

  task automatic test_rr_out_of_order();
    do_reset();
    ch_req = 2'b11; ch_size = {2'd2, 2'd2}; ch_addr[0] = 32'h100; ch_addr[1] = 32'h200;
    arready = 1'b1;
    #1;
    n_checks++; if (addr_ok !== 2'b01) begin n_fail++; $display("FAIL rr_c0: got %b want 01", addr_ok); end
    @(negedge clk); #1;
    n_checks++; if (addr_ok !== 2'b10) begin n_fail++; $display("FAIL rr_c1: got %b want 10", addr_ok); end
    n_checks++; if ({arvalid, arid} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL rr_ar0: got %h want 10", {arvalid, arid}); end
    @(negedge clk); rvalid = 1'b1; rid = 4'd1; rdata = 32'h11111111; #1;
    n_checks++; if (addr_ok !== 2'b00) begin n_fail++; $display("FAIL rr_c2: got %b want 00", addr_ok); end
    n_checks++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h200}) begin n_fail++; $display("FAIL rr_ar1: got %h want 11_00000200", {arvalid, arid, araddr}); end
    @(negedge clk); rid = 4'd0; rdata = 32'h22222222; #1;
    n_checks++; if ({data_ok, rdata_o} !== {2'b10, 32'h11111111}) begin n_fail++; $display("FAIL rr_done1: got %h want 2_11111111", {data_ok, rdata_o}); end
    n_checks++; if (addr_ok !== 2'b00) begin n_fail++; $display("FAIL rr_c3: got %b want 00", addr_ok); end
    @(negedge clk); rvalid = 1'b0; #1;
    n_checks++; if ({data_ok, rdata_o} !== {2'b01, 32'h22222222}) begin n_fail++; $display("FAIL rr_done0: got %h want 1_22222222", {data_ok, rdata_o}); end
    n_checks++; if (addr_ok !== 2'b10) begin n_fail++; $display("FAIL rr_c4: got %b want 10", addr_ok); end
    @(negedge clk); #1;
    n_checks++; if (addr_ok !== 2'b01) begin n_fail++; $display("FAIL rr_c5: got %b want 01", addr_ok); end
    n_checks++; if (arid !== 4'd1) begin n_fail++; $display("FAIL rr_ar_c5: got %h want 1", arid); end
    ch_req = 2'b00;
  endtask

  task automatic test_write();
    do_reset();
    ch_req = 2'b11; ch_wr = 2'b11; ch_size[0] = 2'd1; ch_addr[0] = 32'h2000;
    ch_wdata[0] = 32'hCAFEF00D; ch_wstrb[0] = 4'b0011;
    ch_size[1] = 2'd2; ch_addr[1] = 32'h2100; ch_wdata[1] = 32'h12345678; ch_wstrb[1] = 4'hF;
    awready = 1'b1; wready = 1'b0;
    #1;
    n_checks++; if (addr_ok !== 2'b01) begin n_fail++; $display("FAIL wr_addr_ok: got %b want 01", addr_ok); end
    @(negedge clk); ch_req = 2'b10; #1;
    n_checks++; if ({awvalid, wvalid} !== 2'b11) begin n_fail++; $display("FAIL wr_valids: got %b want 11", {awvalid, wvalid}); end
    n_checks++; if ({awid, awaddr, awsize} !== {4'd0, 32'h2000, 3'd1}) begin n_fail++; $display("FAIL wr_aw: got %h want %h", {awid, awaddr, awsize}, {4'd0, 32'h2000, 3'd1}); end
    n_checks++; if ({wid, wdata, wstrb, wlast} !== {4'd0, 32'hCAFEF00D, 4'b0011, 1'b1}) begin n_fail++; $display("FAIL wr_w: got %h want %h", {wid, wdata, wstrb, wlast}, {4'd0, 32'hCAFEF00D, 4'b0011, 1'b1}); end
    n_checks++; if (addr_ok !== 2'b00) begin n_fail++; $display("FAIL wr_block_c1: got %b want 00", addr_ok); end
    @(negedge clk); #1;
    n_checks++; if ({awvalid, wvalid} !== 2'b01) begin n_fail++; $display("FAIL wr_c2: got %b want 01", {awvalid, wvalid}); end
    @(negedge clk); wready = 1'b1; #1;
    n_checks++; if ({awvalid, wvalid} !== 2'b01) begin n_fail++; $display("FAIL wr_c3: got %b want 01", {awvalid, wvalid}); end
    @(negedge clk); wready = 1'b0; bvalid = 1'b1; bid = 4'd0; #1;
    n_checks++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL wr_w_drop: got %b want 0", wvalid); end
    n_checks++; if (addr_ok !== 2'b00) begin n_fail++; $display("FAIL wr_block_c4: got %b want 00", addr_ok); end
    @(negedge clk); bvalid = 1'b0; #1;
    n_checks++; if (data_ok !== 2'b01) begin n_fail++; $display("FAIL wr_data_ok: got %b want 01", data_ok); end
    n_checks++; if (addr_ok !== 2'b00) begin n_fail++; $display("FAIL wr_block_c5: got %b want 00", addr_ok); end
    @(negedge clk); #1;
    n_checks++; if (addr_ok !== 2'b10) begin n_fail++; $display("FAIL wr_ch1_accept: got %b want 10", addr_ok); end
    @(negedge clk); ch_req = 2'b00; #1;
    n_checks++; if ({awvalid, awid, awaddr} !== {1'b1, 4'd1, 32'h2100}) begin n_fail++; $display("FAIL wr_ch1_aw: got %h want 11_00002100", {awvalid, awid, awaddr}); end
  endtask

  task automatic test_raw();
    do_reset();
    ch_req = 2'b01; ch_wr = 2'b01; ch_size[0] = 2'd2; ch_addr[0] = 32'h3004; ch_wstrb[0] = 4'hF;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    #1;
    n_checks++; if (addr_ok !== 2'b01) begin n_fail++; $display("FAIL raw_wr_accept: got %b want 01", addr_ok); end
    @(negedge clk); ch_req = 2'b10; ch_size[1] = 2'd1; ch_addr[1] = 32'h3006; #1;
    n_checks++; if (addr_ok !== 2'b00) begin n_fail++; $display("FAIL raw_hold_c1: got %b want 00", addr_ok); end
    @(negedge clk); #1;
    n_checks++; if (addr_ok !== 2'b00) begin n_fail++; $display("FAIL raw_hold_c2: got %b want 00", addr_ok); end
    @(negedge clk); ch_addr[1] = 32'h3008; #1;
    n_checks++; if (addr_ok !== 2'b10) begin n_fail++; $display("FAIL raw_other_word: got %b want 10", addr_ok); end
    @(negedge clk); ch_req = 2'b00; rvalid = 1'b1; rid = 4'd1; rdata = 32'h33333333; #1;
    n_checks++; if ({arvalid, araddr} !== {1'b1, 32'h3008}) begin n_fail++; $display("FAIL raw_ar: got %h want 1_00003008", {arvalid, araddr}); end
    @(negedge clk); rvalid = 1'b0; #1;
    n_checks++; if ({data_ok, rdata_o} !== {2'b10, 32'h33333333}) begin n_fail++; $display("FAIL raw_rd_done: got %h want 2_33333333", {data_ok, rdata_o}); end
    @(negedge clk); ch_req = 2'b10; ch_addr[1] = 32'h3006; bvalid = 1'b1; bid = 4'd0; #1;
    n_checks++; if (addr_ok !== 2'b00) begin n_fail++; $display("FAIL raw_hold_c6: got %b want 00", addr_ok); end
    @(negedge clk); bvalid = 1'b0; #1;
    n_checks++; if ({data_ok, addr_ok} !== 4'b0100) begin n_fail++; $display("FAIL raw_c7: got %b want 0100", {data_ok, addr_ok}); end
    @(negedge clk); #1;
    n_checks++; if (addr_ok !== 2'b10) begin n_fail++; $display("FAIL raw_release: got %b want 10", addr_ok); end
    @(negedge clk); ch_req = 2'b00; #1;
    n_checks++; if ({arvalid, araddr} !== {1'b1, 32'h3006}) begin n_fail++; $display("FAIL raw_ar2: got %h want 1_00003006", {arvalid, araddr}); end
  endtask

  task automatic test_bad_id();
    do_reset();
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hBADBAD00;
    @(negedge clk); rvalid = 1'b0; #1;
    n_checks++; if (data_ok !== 2'b00) begin n_fail++; $display("FAIL bad_data_ok: got %b want 00", data_ok); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err_set: got %b want 1", err); end
    n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL bad_rdata: got %h want 0", rdata_o); end
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err_sticky: got %b want 1", err); end
    do_reset();
    #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bad_err_clear: got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ch_req = 2'b01; ch_size[0] = 2'd2; ch_addr[0] = 32'h4000; arready = 1'b0;
    #1;
    n_checks++; if (addr_ok !== 2'b01) begin n_fail++; $display("FAIL mid_accept: got %b want 01", addr_ok); end
    @(negedge clk); ch_req = 2'b00; rst = 1'b1; #1;
    n_checks++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL mid_arvalid: got %b want 1", arvalid); end
    @(negedge clk); rst = 1'b0; ch_req = 2'b11; ch_addr[1] = 32'h5000; arready = 1'b1; #1;
    n_checks++; if ({arvalid, data_ok} !== 3'b000) begin n_fail++; $display("FAIL mid_dropped: got %b want 000", {arvalid, data_ok}); end
    n_checks++; if (addr_ok !== 2'b01) begin n_fail++; $display("FAIL mid_ptr0: got %b want 01", addr_ok); end
    @(negedge clk); ch_req = 2'b00; #1;
    n_checks++; if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h4000}) begin n_fail++; $display("FAIL mid_reissue: got %h want 10_00004000", {arvalid, arid, araddr}); end
    n_checks++; if (data_ok !== 2'b00) begin n_fail++; $display("FAIL mid_no_ok: got %b want 00", data_ok); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_out_of_order();
    test_write();
    test_raw();
    test_bad_id();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
